polyphase_framer: RTL and testbench

POLYPHASE_FRAMER -- requirements
Module: polyphase_framer

---
 rtl/polyphase_framer.sv | 252 +++++++++++++++++++++++++
 tb/tb_polyphase_framer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_framer.sv
// polyphase_framer
//   Gathers a serial sample stream into LANES-wide parallel frames for a
//   parallel processing core, and serialises the core's result frames back
//   into a serial output stream.
//
//   Input side : a phase counter steers each valid sample into a gather
//                lane. The sample that completes a frame is merged directly,
//                and the frame is registered with a one-cycle strobe.
//   Output side: a two-state serialiser (IDLE/SHIFT) with a one-frame
//                holding register. It emits lanes back-to-back with no
//                bubble when a frame is waiting. A frame that cannot be
//                accepted is dropped and flagged on the sticky ovf.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      asynchronous active-low reset
//   sync_clr   synchronous clear of phase, gather buffer and serialiser
//   in_valid   in_data carries a new sample this cycle
//   in_data    serial input sample (IN_W, signed)
//   frm_valid  one-cycle strobe: frm_data holds a complete frame
//   frm_data   gathered frame, lane k at [k*IN_W +: IN_W], lane 0 oldest
//   res_valid  result frame from the parallel core is present
//   res_data   result frame, lane k at [k*OUT_W +: OUT_W]
//   out_valid  out_data carries a serial output sample
//   out_data   serial output sample (OUT_W, signed)
//   ovf        sticky overflow: a result frame was discarded
module polyphase_framer #(
    parameter int LANES = 3,
    parameter int IN_W  = 11,
    parameter int OUT_W = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sync_clr,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_data,
    output logic                   frm_valid,
    output logic [LANES*IN_W-1:0]  frm_data,
    input  logic                   res_valid,
    input  logic [LANES*OUT_W-1:0] res_data,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data,
    output logic                   ovf
);

    localparam int PH_W = $clog2(LANES);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(LANES - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // ---------------------------------------------------------------
    // Gather side
    // ---------------------------------------------------------------
    logic [PH_W-1:0]       ph_r;
    logic [IN_W-1:0]       gather_r [LANES];
    logic                  frm_valid_r;
    logic [LANES*IN_W-1:0] frm_data_r;
    logic [LANES*IN_W-1:0] frame_s;

    // Assemble the completed frame; the final lane comes straight from the
    // incoming sample so the frame can be registered on the same edge.
    always_comb begin
        frame_s = {(LANES*IN_W){1'b0}};
        for (int k = 0; k < LANES - 1; k++) begin
            frame_s[k*IN_W +: IN_W] = gather_r[k];
        end
        frame_s[(LANES-1)*IN_W +: IN_W] = in_data;
    end

    // Phase counter, gather buffer and frame output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_r        <= {PH_W{1'b0}};
            frm_valid_r <= 1'b0;
            frm_data_r  <= {(LANES*IN_W){1'b0}};
            for (int k = 0; k < LANES; k++) begin
                gather_r[k] <= {IN_W{1'b0}};
            end
        end else if (sync_clr) begin
            ph_r        <= {PH_W{1'b0}};
            frm_valid_r <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                gather_r[k] <= {IN_W{1'b0}};
            end
        end else begin
            frm_valid_r <= 1'b0;
            if (in_valid) begin
                gather_r[ph_r] <= in_data;
                if (ph_r == PH_LAST) begin
                    ph_r        <= {PH_W{1'b0}};
                    frm_valid_r <= 1'b1;
                    frm_data_r  <= frame_s;
                end else begin
                    ph_r <= ph_r + PH_W'(1);
                end
            end
        end
    end

    assign frm_valid = frm_valid_r;
    assign frm_data  = frm_data_r;

    // ---------------------------------------------------------------
    // Serialiser side
    // ---------------------------------------------------------------
    ser_state_t             state_r;
    ser_state_t             state_next_s;
    logic [PH_W-1:0]        idx_r;
    logic [LANES*OUT_W-1:0] shreg_r;
    logic [LANES*OUT_W-1:0] hold_r;
    logic                   hold_full_r;
    logic                   ovf_r;
    logic                   out_valid_r;
    logic [OUT_W-1:0]       out_data_r;

    logic                   last_s;
    logic                   load_s;
    logic                   load_hold_s;
    logic                   adv_s;
    logic                   hold_wr_s;
    logic                   hold_clr_s;
    logic                   ovf_set_s;
    logic [LANES*OUT_W-1:0] load_src_s;

    assign last_s = (idx_r == PH_LAST);

    // Serialiser state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else if (sync_clr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control. HOLD can only be occupied while
    // shifting, so IDLE never has to consider it.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        load_hold_s  = 1'b0;
        adv_s        = 1'b0;
        hold_wr_s    = 1'b0;
        hold_clr_s   = 1'b0;
        ovf_set_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (res_valid) begin
                    load_s       = 1'b1;
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    if (hold_full_r) begin
                        // Promote HOLD; a coincident frame refills it.
                        load_s       = 1'b1;
                        load_hold_s  = 1'b1;
                        state_next_s = SHIFT;
                        if (res_valid) begin
                            hold_wr_s = 1'b1;
                        end else begin
                            hold_clr_s = 1'b1;
                        end
                    end else if (res_valid) begin
                        load_s       = 1'b1;
                        state_next_s = SHIFT;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    adv_s = 1'b1;
                    if (res_valid) begin
                        if (hold_full_r) begin
                            ovf_set_s = 1'b1;
                        end else begin
                            hold_wr_s = 1'b1;
                        end
                    end else begin
                        ovf_set_s = 1'b0;
                    end
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Select where a newly loaded frame comes from.
    always_comb begin
        if (load_hold_s) begin
            load_src_s = hold_r;
        end else begin
            load_src_s = res_data;
        end
    end

    // Shift register, lane index, HOLD, overflow flag and registered
    // serial output. out_data_r always mirrors the lane being emitted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r       <= {PH_W{1'b0}};
            shreg_r     <= {(LANES*OUT_W){1'b0}};
            hold_r      <= {(LANES*OUT_W){1'b0}};
            hold_full_r <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
        end else if (sync_clr) begin
            idx_r       <= {PH_W{1'b0}};
            shreg_r     <= {(LANES*OUT_W){1'b0}};
            hold_r      <= {(LANES*OUT_W){1'b0}};
            hold_full_r <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
        end else begin
            out_valid_r <= (state_next_s == SHIFT);
            if (load_s) begin
                shreg_r    <= load_src_s;
                idx_r      <= {PH_W{1'b0}};
                out_data_r <= load_src_s[OUT_W-1:0];
            end else if (adv_s) begin
                shreg_r    <= shreg_r >> OUT_W;
                idx_r      <= idx_r + PH_W'(1);
                out_data_r <= shreg_r[OUT_W +: OUT_W];
            end
            if (hold_wr_s) begin
                hold_r      <= res_data;
                hold_full_r <= 1'b1;
            end else if (hold_clr_s) begin
                hold_full_r <= 1'b0;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_polyphase_framer.sv
// Self-checking bench for polyphase_framer.
//   u3: default LANES=3, IN_W=11, OUT_W=11, driven by directed and random
//       stimulus; expectations come from a queue-based reference model and
//       are checked by a decoupled negedge monitor.
//   u4: LANES=4, IN_W=16, OUT_W=16 with the result port looped back from
//       the frame port; the serial output must reproduce the input stream.
module tb_polyphase_framer;

    localparam int L  = 3;
    localparam int W  = 11;
    localparam int L4 = 4;
    localparam int W4 = 16;

    logic           clk;
    logic           reset;
    logic           sync_clr;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           frm_valid;
    logic [L*W-1:0] frm_data;
    logic           res_valid;
    logic [L*W-1:0] res_data;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           ovf;

    logic             sc4;
    logic             in_valid4;
    logic [W4-1:0]    in_data4;
    logic             frm_valid4;
    logic [L4*W4-1:0] frm_data4;
    logic             out_valid4;
    logic [W4-1:0]    out_data4;
    logic             ovf4;

    polyphase_framer u3 (
        .clk(clk), .reset(reset), .sync_clr(sync_clr),
        .in_valid(in_valid), .in_data(in_data),
        .frm_valid(frm_valid), .frm_data(frm_data),
        .res_valid(res_valid), .res_data(res_data),
        .out_valid(out_valid), .out_data(out_data), .ovf(ovf)
    );

    polyphase_framer #(.LANES(L4), .IN_W(W4), .OUT_W(W4)) u4 (
        .clk(clk), .reset(reset), .sync_clr(sc4),
        .in_valid(in_valid4), .in_data(in_data4),
        .frm_valid(frm_valid4), .frm_data(frm_data4),
        .res_valid(frm_valid4), .res_data(frm_data4),
        .out_valid(out_valid4), .out_data(out_data4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model (LANES=3 instance) ----------------
    logic [W-1:0]   gath_q [$];   // samples received for the frame in progress
    logic [L*W-1:0] frm_q  [$];   // frames expected on frm_valid
    logic [W-1:0]   out_q  [$];   // serial samples expected on out_valid
    int             rem = 0;      // accepted output samples still to be emitted
    bit             exp_ovf = 1'b0;
    bit             exp_ov  = 1'b0;

    task automatic model_clear();
        gath_q.delete(); frm_q.delete(); out_q.delete();
        rem = 0; exp_ovf = 1'b0; exp_ov = 1'b0;
    endtask

    // One clock of stimulus; the model is advanced with the values applied.
    task automatic cyc(input bit iv, input logic [W-1:0] d, input bit rv,
                       input logic [L*W-1:0] rd, input bit sc);
        logic [L*W-1:0] f;
        int rn;
        in_valid = iv; in_data = d; res_valid = rv; res_data = rd; sync_clr = sc;
        @(posedge clk);
        if (sc) begin
            model_clear();
        end else begin
            if (iv) begin
                gath_q.push_back(d);
                if (gath_q.size() == L) begin
                    for (int k = 0; k < L; k++) f[k*W +: W] = gath_q[k];
                    frm_q.push_back(f);
                    gath_q.delete();
                end
            end
            // At most one frame in flight plus one waiting: a new frame fits
            // only if no more than LANES+1 samples remain to be emitted.
            rn = (rem > 0) ? rem - 1 : 0;
            if (rv) begin
                if (rem <= L + 1) begin
                    rn += L;
                    for (int k = 0; k < L; k++) out_q.push_back(rd[k*W +: W]);
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            rem = rn;
            exp_ov = (rem > 0);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [L*W-1:0] mk3(input int a, input int b, input int c);
        logic [W-1:0] la, lb, lc;
        la = W'(a); lb = W'(b); lc = W'(c);
        return {lc, lb, la};
    endfunction

    // ---------------- monitor (LANES=3 instance) ----------------
    logic [L*W-1:0] exp_f;
    logic [W-1:0]   exp_s;

    // Compare DUT outputs against the scoreboard away from the active edge.
    always @(negedge clk) begin
        check("frm_valid", frm_valid, (frm_q.size() != 0));
        if (frm_valid && frm_q.size() != 0) begin
            exp_f = frm_q.pop_front();
            check("frm_data", frm_data, exp_f);
        end
        check("out_valid", out_valid, exp_ov);
        if (out_valid) begin
            if (out_q.size() == 0) begin
                n_checks++;
                $display("FAIL out_data: got %0h expected nothing pending at %0t", out_data, $time);
            end else begin
                exp_s = out_q.pop_front();
                check("out_data", out_data, exp_s);
            end
        end
        check("ovf", ovf, exp_ovf);
    end

    // ---------------- LANES=4 loopback checking ----------------
    logic [W4-1:0] in4_q [$];
    bit  l4_en = 1'b0;
    bit  l4_started = 1'b0;
    int  cyc4 = 0;
    int  last_frm4 = -1;
    logic [W4-1:0] exp4;

    // Frame cadence and gap-free loopback on the wider instance.
    always @(negedge clk) begin
        if (l4_en) begin
            cyc4++;
            if (frm_valid4) begin
                if (last_frm4 >= 0) check("l4_frm_period", 64'(cyc4 - last_frm4), 64'd4);
                last_frm4 = cyc4;
            end
            if (out_valid4) l4_started = 1'b1;
            if (l4_started) check("l4_out_valid", out_valid4, (in4_q.size() != 0));
            if (out_valid4 && in4_q.size() != 0) begin
                exp4 = in4_q.pop_front();
                check("l4_out_data", out_data4, exp4);
            end
            check("l4_ovf", ovf4, 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; sync_clr = 1'b0; in_valid = 1'b0; in_data = '0;
        res_valid = 1'b0; res_data = '0;
        sc4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_frm_valid", frm_valid, 1'b0);
        check("rst_frm_data",  frm_data,  '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  '0);
        check("rst_ovf",       ovf,       1'b0);
        reset = 1'b1;

        // Back-to-back samples form frame {1,2,3}.
        cyc(1'b1, 11'd1, 1'b0, '0, 1'b0);
        cyc(1'b1, 11'd2, 1'b0, '0, 1'b0);
        cyc(1'b1, 11'd3, 1'b0, '0, 1'b0);
        idle(3);

        // Gaps between samples keep the phase.
        cyc(1'b1, 11'd5, 1'b0, '0, 1'b0);
        idle(1);
        cyc(1'b1, 11'd6, 1'b0, '0, 1'b0);
        idle(2);
        cyc(1'b1, 11'd7, 1'b0, '0, 1'b0);
        idle(3);

        // Serialise, with the next frame arriving on the final shift cycle.
        cyc(1'b0, '0, 1'b1, mk3(10, 20, 30), 1'b0);
        idle(2);
        cyc(1'b0, '0, 1'b1, mk3(40, 50, 60), 1'b0);
        idle(5);

        // Three frames on consecutive cycles: the third overflows.
        cyc(1'b0, '0, 1'b1, mk3(100, 101, 102), 1'b0);
        cyc(1'b0, '0, 1'b1, mk3(200, 201, 202), 1'b0);
        cyc(1'b0, '0, 1'b1, mk3(300, 301, 302), 1'b0);
        idle(8);
        check("ovf_sticky", ovf, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        idle(2);

        // Asynchronous reset mid-frame and mid-shift.
        cyc(1'b1, 11'd1, 1'b1, mk3(1, 2, 3), 1'b0);
        cyc(1'b1, 11'd2, 1'b0, '0, 1'b0);
        reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_data",  out_data,  '0);
        check("arst_frm_data",  frm_data,  '0);
        check("arst_ovf",       ovf,       1'b0);
        model_clear();
        in_valid = 1'b0; res_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b1, 11'd7, 1'b0, '0, 1'b0);
        cyc(1'b1, 11'd8, 1'b0, '0, 1'b0);
        cyc(1'b1, 11'd9, 1'b0, '0, 1'b0);
        idle(3);

        // Random traffic, including occasional synchronous clears.
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 1) == 1), W'($urandom),
                ($urandom_range(0, 3) == 0), (L*W)'({$urandom, $urandom}),
                ($urandom_range(0, 63) == 0));
        end
        idle(12);
        check("frm_q_drained", 64'(frm_q.size()), 64'd0);
        check("out_q_drained", 64'(out_q.size()), 64'd0);

        // Wider instance: continuous stream looped back through the core port.
        l4_en = 1'b1;
        for (int i = 0; i < 48; i++) begin
            in_valid4 = 1'b1;
            in_data4  = W4'($urandom);
            @(posedge clk);
            in4_q.push_back(in_data4);
            #1;
        end
        in_valid4 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("l4_drained", 64'(in4_q.size()), 64'd0);
        check("l4_started", l4_started, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
